// File: rtl/step_counter.sv
// Step counter for the sequential multiplier: counts add-shift / shift steps
// against a terminal count loaded at start, flags the last step and pulses done.
module step_counter #(
    parameter int WIDTH_C     = 4,
    parameter bit HOLD_AT_END = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH_C-1:0] limit,
    input  logic               add_shift,
    input  logic               shift,
    input  logic               abort,
    output logic [WIDTH_C-1:0] count,
    output logic               count_check,
    output logic               busy,
    output logic               done,
    output logic               stray_step
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [WIDTH_C-1:0]   r_count;
    logic [WIDTH_C-1:0]   r_limit;
    logic                 r_done;
    logic                 r_stray;

    state_t               w_state_nx;
    logic [WIDTH_C-1:0]   w_count_nx;
    logic [WIDTH_C-1:0]   w_limit_nx;
    logic                 w_done_nx;
    logic                 w_stray_nx;
    logic                 w_step;
    logic                 w_at_limit;

    assign w_step     = add_shift | shift;
    assign w_at_limit = (r_count == r_limit);

    // State register: every piece of state updates together on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_limit <= '0;
            r_done  <= 1'b0;
            r_stray <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_limit <= w_limit_nx;
            r_done  <= w_done_nx;
            r_stray <= w_stray_nx;
        end
    end

    // Next-state logic; abort beats start, start beats any step in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_limit_nx = r_limit;
        w_done_nx  = 1'b0;
        w_stray_nx = r_stray;
        if (abort) begin
            w_state_nx = S_IDLE;
            w_count_nx = '0;
        end else if (start) begin
            w_state_nx = S_RUN;
            w_count_nx = '0;
            w_limit_nx = limit;
            w_stray_nx = 1'b0;
        end else if (w_step) begin
            if (r_state == S_RUN) begin
                if (w_at_limit) begin
                    w_state_nx = S_IDLE;
                    w_count_nx = HOLD_AT_END ? r_limit : '0;
                    w_done_nx  = 1'b1;
                end else begin
                    w_count_nx = r_count + WIDTH_C'(1);
                end
            end else begin
                w_stray_nx = 1'b1;
            end
        end
    end

    // Outputs come from registered state only.
    always_comb begin
        busy        = (r_state == S_RUN);
        count       = r_count;
        done        = r_done;
        stray_step  = r_stray;
        count_check = (r_state == S_RUN) & w_at_limit;
    end

endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter: three instances cover the HOLD_AT_END
// variants at WIDTH_C=4 and the WIDTH_C=6 boundary limits.
module tb_step_counter;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] limit;
    logic [5:0] limit6;
    logic       add_shift;
    logic       shift;
    logic       abort;

    logic [3:0] a_count;
    logic       a_cc, a_busy, a_done, a_stray;
    logic [3:0] b_count;
    logic       b_cc, b_busy, b_done, b_stray;
    logic [5:0] c_count;
    logic       c_cc, c_busy, c_done, c_stray;

    int n_total;
    int n_bad;

    step_counter #(.WIDTH_C(4), .HOLD_AT_END(1'b0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .limit(limit),
        .add_shift(add_shift), .shift(shift), .abort(abort),
        .count(a_count), .count_check(a_cc), .busy(a_busy),
        .done(a_done), .stray_step(a_stray)
    );

    step_counter #(.WIDTH_C(4), .HOLD_AT_END(1'b1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .limit(limit),
        .add_shift(add_shift), .shift(shift), .abort(abort),
        .count(b_count), .count_check(b_cc), .busy(b_busy),
        .done(b_done), .stray_step(b_stray)
    );

    step_counter #(.WIDTH_C(6), .HOLD_AT_END(1'b0)) dut_c (
        .clk(clk), .reset(reset), .start(start), .limit(limit6),
        .add_shift(add_shift), .shift(shift), .abort(abort),
        .count(c_count), .count_check(c_cc), .busy(c_busy),
        .done(c_done), .stray_step(c_stray)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        cyc();
        cyc();
        n_total++;
        if ({a_count, a_cc, a_busy, a_done, a_stray} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_a: got count=%0d cc=%b busy=%b done=%b stray=%b, want all 0",
                     a_count, a_cc, a_busy, a_done, a_stray);
        end
        n_total++;
        if ({c_count, c_cc, c_busy, c_done, c_stray} !== 10'h000) begin
            n_bad++;
            $display("FAIL reset_c: got count=%0d busy=%b done=%b, want all 0",
                     c_count, c_busy, c_done);
        end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_full_run;
        limit = 4'd15;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (a_count !== 4'(i) || a_busy !== 1'b1 || a_cc !== (i == 15) || a_done !== 1'b0) begin
                n_bad++;
                $display("FAIL full_run_step%0d: got count=%0d busy=%b cc=%b done=%b, want count=%0d busy=1 cc=%b done=0",
                         i, a_count, a_busy, a_cc, a_done, i, (i == 15));
            end
            add_shift = 1'b1;
            cyc();
        end
        add_shift = 1'b0;
        n_total++;
        if (a_count !== 4'd0 || a_busy !== 1'b0 || a_done !== 1'b1 || a_cc !== 1'b0) begin
            n_bad++;
            $display("FAIL full_run_end: got count=%0d busy=%b done=%b cc=%b, want 0 0 1 0",
                     a_count, a_busy, a_done, a_cc);
        end
        cyc();
        n_total++;
        if (a_done !== 1'b0 || a_count !== 4'd0) begin
            n_bad++;
            $display("FAIL full_run_pulse: got done=%b count=%0d, want done=0 count=0", a_done, a_count);
        end
    endtask

    task automatic test_hold;
        limit = 4'd5;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (b_cc !== (i == 5)) begin
                n_bad++;
                $display("FAIL hold_cc%0d: got cc=%b, want %b", i, b_cc, (i == 5));
            end
            if (i % 2 == 0) shift = 1'b1;
            else            add_shift = 1'b1;
            cyc();
            shift     = 1'b0;
            add_shift = 1'b0;
            n_total++;
            if (i < 5) begin
                if (b_count !== 4'(i + 1) || b_busy !== 1'b1 || b_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL hold_step%0d: got count=%0d busy=%b done=%b, want count=%0d busy=1 done=0",
                             i, b_count, b_busy, b_done, i + 1);
                end
            end else begin
                if (b_count !== 4'd5 || b_busy !== 1'b0 || b_done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL hold_end: got count=%0d busy=%b done=%b, want count=5 busy=0 done=1",
                             b_count, b_busy, b_done);
                end
            end
            cyc();
            n_total++;
            if (b_count !== 4'((i < 5) ? i + 1 : 5) || b_done !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_gap%0d: got count=%0d done=%b, want count=%0d done=0",
                         i, b_count, b_done, (i < 5) ? i + 1 : 5);
            end
        end
    endtask

    task automatic test_stray;
        shift = 1'b1;
        cyc();
        shift = 1'b0;
        n_total++;
        if (b_stray !== 1'b1 || b_count !== 4'd5 || b_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_set_b: got stray=%b count=%0d busy=%b, want stray=1 count=5 busy=0",
                     b_stray, b_count, b_busy);
        end
        n_total++;
        if (a_stray !== 1'b1 || a_count !== 4'd0) begin
            n_bad++;
            $display("FAIL stray_set_a: got stray=%b count=%0d, want stray=1 count=0", a_stray, a_count);
        end
        cyc();
        n_total++;
        if (b_stray !== 1'b1) begin
            n_bad++;
            $display("FAIL stray_sticky: got stray=%b, want 1", b_stray);
        end
        limit = 4'd1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_total++;
        if (b_stray !== 1'b0 || a_stray !== 1'b0 || b_count !== 4'd0 || b_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stray_clear: got b_stray=%b a_stray=%b b_count=%0d b_busy=%b, want 0 0 0 1",
                     b_stray, a_stray, b_count, b_busy);
        end
    endtask

    task automatic test_both_inputs;
        limit = 4'd3;
        start = 1'b1;
        cyc();
        start     = 1'b0;
        add_shift = 1'b1;
        shift     = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_total++;
            if (k < 4) begin
                if (a_count !== 4'(k) || a_done !== 1'b0 || a_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL both_step%0d: got count=%0d done=%b busy=%b, want count=%0d done=0 busy=1",
                             k, a_count, a_done, a_busy, k);
                end
            end else begin
                if (a_count !== 4'd0 || a_done !== 1'b1 || a_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL both_end: got count=%0d done=%b busy=%b, want 0 1 0",
                             a_count, a_done, a_busy);
                end
            end
        end
        add_shift = 1'b0;
        shift     = 1'b0;
        n_total++;
        if (a_stray !== 1'b0) begin
            n_bad++;
            $display("FAIL both_no_stray: got stray=%b, want 0", a_stray);
        end
        cyc();
    endtask

    task automatic test_abort;
        limit = 4'd15;
        start = 1'b1;
        cyc();
        start     = 1'b0;
        add_shift = 1'b1;
        repeat (7) cyc();
        add_shift = 1'b0;
        n_total++;
        if (a_count !== 4'd7) begin
            n_bad++;
            $display("FAIL abort_pre: got count=%0d, want 7", a_count);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        n_total++;
        if (a_count !== 4'd0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_cc !== 1'b0) begin
            n_bad++;
            $display("FAIL abort: got count=%0d busy=%b done=%b cc=%b, want all 0",
                     a_count, a_busy, a_done, a_cc);
        end
        cyc();
        n_total++;
        if (a_done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: got done=%b, want 0", a_done);
        end
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        n_total++;
        if (a_busy !== 1'b0 || a_count !== 4'd0) begin
            n_bad++;
            $display("FAIL abort_beats_start: got busy=%b count=%0d, want busy=0 count=0", a_busy, a_count);
        end
    endtask

    task automatic test_restart;
        limit = 4'd15;
        start = 1'b1;
        cyc();
        start     = 1'b0;
        add_shift = 1'b1;
        repeat (9) cyc();
        n_total++;
        if (a_count !== 4'd9 || a_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_pre: got count=%0d busy=%b, want count=9 busy=1", a_count, a_busy);
        end
        limit = 4'd2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_total++;
        if (a_count !== 4'd0 || a_busy !== 1'b1 || a_done !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_load: got count=%0d busy=%b done=%b, want 0 1 0", a_count, a_busy, a_done);
        end
        repeat (2) cyc();
        n_total++;
        if (a_count !== 4'd2 || a_cc !== 1'b1 || a_done !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_last: got count=%0d cc=%b done=%b, want count=2 cc=1 done=0",
                     a_count, a_cc, a_done);
        end
        // Back-to-back: start again while done is high
        cyc();
        add_shift = 1'b0;
        n_total++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_count !== 4'd0) begin
            n_bad++;
            $display("FAIL restart_done: got done=%b busy=%b count=%0d, want 1 0 0", a_done, a_busy, a_count);
        end
        limit = 4'd4;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_total++;
        if (a_busy !== 1'b1 || a_done !== 1'b0 || a_count !== 4'd0) begin
            n_bad++;
            $display("FAIL back_to_back: got busy=%b done=%b count=%0d, want 1 0 0", a_busy, a_done, a_count);
        end
    endtask

    task automatic test_reset_mid_run;
        limit = 4'd15;
        start = 1'b1;
        cyc();
        start     = 1'b0;
        add_shift = 1'b1;
        repeat (4) cyc();
        reset = 1'b0;
        cyc();
        reset     = 1'b1;
        add_shift = 1'b0;
        n_total++;
        if ({a_count, a_cc, a_busy, a_done, a_stray} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_run: got count=%0d cc=%b busy=%b done=%b stray=%b, want all 0",
                     a_count, a_cc, a_busy, a_done, a_stray);
        end
        cyc();
        n_total++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_done: got done=%b busy=%b, want 0 0", a_done, a_busy);
        end
    endtask

    task automatic test_w6_limits;
        limit6 = 6'd0;
        start  = 1'b1;
        cyc();
        start = 1'b0;
        n_total++;
        if (c_cc !== 1'b1 || c_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL w6_lim0_cc: got cc=%b busy=%b, want 1 1", c_cc, c_busy);
        end
        add_shift = 1'b1;
        cyc();
        add_shift = 1'b0;
        n_total++;
        if (c_done !== 1'b1 || c_busy !== 1'b0 || c_count !== 6'd0) begin
            n_bad++;
            $display("FAIL w6_lim0_done: got done=%b busy=%b count=%0d, want 1 0 0", c_done, c_busy, c_count);
        end
        limit6 = 6'd63;
        start  = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            n_total++;
            if (c_count !== 6'(i) || c_cc !== (i == 63) || c_done !== 1'b0 || c_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL w6_lim63_step%0d: got count=%0d cc=%b done=%b busy=%b, want count=%0d cc=%b done=0 busy=1",
                         i, c_count, c_cc, c_done, c_busy, i, (i == 63));
            end
            add_shift = 1'b1;
            cyc();
        end
        add_shift = 1'b0;
        n_total++;
        if (c_done !== 1'b1 || c_busy !== 1'b0 || c_count !== 6'd0) begin
            n_bad++;
            $display("FAIL w6_lim63_done: got done=%b busy=%b count=%0d, want 1 0 0", c_done, c_busy, c_count);
        end
        cyc();
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b0;
        start     = 1'b0;
        limit     = '0;
        limit6    = '0;
        add_shift = 1'b0;
        shift     = 1'b0;
        abort     = 1'b0;
        #1;
        test_reset();
        test_full_run();
        test_hold();
        test_stray();
        test_both_inputs();
        test_abort();
        test_restart();
        test_reset_mid_run();
        test_w6_limits();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/step_counter.md
# step_counter

Parametrised step counter for the sequential multiplier datapath, the successor of the fixed 4-bit add/shift counter. It tracks how many add-shift or shift steps the controller has issued against a programmable terminal count loaded at `start`. It reports progress, flags the final step, and emits a one-cycle `done` pulse. It sits between the multiplier control FSM and its operand registers, and is sized by operand width rather than hard-wired to 16 steps.

## Interface
Parameters:
- `WIDTH_C`, 4: counter and limit width in bits; must be ≥ 1.
- `HOLD_AT_END`, 0: after the terminal step, 0 returns `count` to 0 and 1 holds `count` at the limit value.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  input  1  loads `limit`, clears `count`, enters RUN.
- `limit`  input  WIDTH_C  terminal count; sampled only when `start` is high.
- `add_shift`  input  1  add-and-shift step request.
- `shift`  input  1  shift-only step request.
- `abort`  input  1  cancels the operation and returns to IDLE without `done`.
- `count`  output  WIDTH_C  steps completed in the current operation (registered).
- `count_check`  output  1  high while in RUN with `count == limit_q`; marks the last step.
- `busy`  output  1  high while in RUN (registered).
- `done`  output  1  one-cycle pulse after the terminal step (registered).
- `stray_step`  output  1  sticky; set by any step request outside RUN, cleared by `start` or reset.

## Operation
- States: IDLE and RUN. `limit_q` is an internal WIDTH_C register.
- Step event: `step = add_shift | shift`. When both inputs are high in the same cycle, the counter takes exactly one step.
- Edge priority, highest first: reset, then `abort`, then `start`, then step.
- Reset (`reset == 0` at the edge):
  - State goes to IDLE.
  - `count`, `limit_q`, `busy`, `done` and `stray_step` all go to 0.
- `abort` (any state): go to IDLE, `count` = 0, `busy` = 0, `done` = 0. `limit_q` and `stray_step` are unchanged.
- `start` (any state, including RUN):
  - Set `limit_q` = `limit` and `count` = 0, and enter RUN.
  - Clear `stray_step`; `done` = 0.
  - Any step in the same cycle is ignored.
- RUN with step and `count != limit_q`: `count` = `count + 1`.
- RUN with step and `count == limit_q` (terminal step):
  - `count` becomes 0, or stays at `limit_q` when `HOLD_AT_END` = 1.
  - Return to IDLE and set `done` = 1 for exactly one cycle.
- Steps per operation = `limit_q + 1`. `limit` = 0 gives one step; `limit` = 2^WIDTH_C−1 gives 2^WIDTH_C steps, which matches the legacy 16-step behaviour at WIDTH_C = 4.
- Arithmetic is unsigned modulo 2^WIDTH_C. `count` never exceeds `limit_q`, so no wrap occurs inside RUN.
- IDLE with step and no `start`/`abort`:
  - `count` is unchanged (it holds its end value).
  - Set `stray_step` = 1.
- `done` clears on the following edge unless re-set. A new `start` is allowed in the same cycle `done` is high.
- `count_check` is combinational from registered state only: `busy & (count == limit_q)`.

## Timing
- Latency:
  - `start` at edge N: `busy` = 1 and `count` = 0 from N.
  - Each step at an edge increments `count` visibly after that edge.
  - Terminal step at edge T: `busy` = 0 and `done` = 1 during cycle T..T+1. `done` = 0 after edge T+1.
- `count_check` is high during the whole cycle in which the terminal step may be issued. The controller may use it to select the final operation.
- Back-to-back operations: a `start` during the `done` cycle gives `busy` = 1 one cycle after it dropped, with no lost cycle beyond that.
- Reset mid-RUN: all outputs are 0 after the edge and no `done` is produced.
- `abort` and `start` in the same cycle: `abort` wins and the block stays in IDLE.
- No combinational path exists from inputs to outputs.

## Test plan
- Reset then full run (WIDTH_C = 4, `limit` = 15, one `add_shift` per cycle):
  - `count` steps 0..15.
  - `count_check` is high only at 15.
  - After the 16th step: `count` = 0, `busy` = 0, `done` pulses once.
- `limit` = 5, `HOLD_AT_END` = 1, alternating `shift`/`add_shift` with idle gaps:
  - Six steps complete the operation.
  - `count` holds at 5 after `done`; no count change during gaps.
- Simultaneous `add_shift` and `shift` with `limit` = 3: `count` advances by 1 per cycle and `done` arrives after 4 cycles.
- Interruptions:
  - `abort` at `count` = 7 gives IDLE, `count` = 0, no `done`.
  - Restart with `start` while RUN at `count` = 9 with new `limit` = 2 gives `count` = 0 and `done` after 3 further steps.
- Stray steps:
  - A step in IDLE sets `stray_step` and leaves `count` unchanged.
  - The next `start` clears `stray_step`.
  - Sync reset asserted mid-RUN clears all outputs on the next edge and produces no `done`.
- WIDTH_C = 6, `limit` = 0 and `limit` = 63: exactly 1 and 64 steps respectively to `done`, and `count_check` aligned with the last step.
